// File: rtl/player_motion_ctrl_pkg.sv
// Shared game definitions: FSM encoding and screen geometry used by the
// motion controller and the player/double_sin placement logic.
package player_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_JUMP = 2'd2,
        ST_DEAD = 2'd3
    } state_e;

    localparam logic [9:0] GROUND_Y = 10'd340;
    localparam logic [9:0] CEIL_Y   = 10'd40;
    localparam logic [9:0] X_WRAP   = 10'd640;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

endpackage

// File: rtl/player_motion_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a one-cycle
// rising-edge pulse.
module player_motion_ctrl_btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            prev_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame game engine: jump/gravity physics, obstacle scroll, wrap-counted
// score and the idle/run/jump/dead state machine.
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter logic [5:0] JUMP_V      = 6'd12,
    parameter logic [5:0] GRAVITY     = 6'd1,
    parameter logic [9:0] SCROLL_STEP = 10'd2,
    parameter logic [9:0] SCROLL_WRAP = X_WRAP,
    parameter logic [7:0] DEAD_FRAMES = 8'd120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_jump,
    input  logic       collision,
    output logic [9:0] y_pos,
    output logic [9:0] x_offset,
    output logic       show_player,
    output logic       game_over,
    output logic [7:0] score
);

    localparam logic signed [10:0] CEIL_S   = {1'b0, CEIL_Y};
    localparam logic signed [10:0] GROUND_S = {1'b0, GROUND_Y};

    state_e             state_q, state_d;
    logic [9:0]         y_q, y_d, x_q, x_d;
    logic signed [6:0]  vel_q, vel_d;
    logic [7:0]         score_q, score_d, dead_cnt_q, dead_cnt_d;
    logic               show_q, show_d, game_over_q;
    logic               jump_req_q, jump_req_d, hit_q, hit_d;
    logic               btn_rise;

    player_motion_ctrl_btn_sync_edge u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_jump),
        .rise  (btn_rise)
    );

    // A tick consumes the pending request; an edge landing on the tick is kept for the next one.
    assign jump_req_d = btn_rise | (jump_req_q & ~frame_tick);
    assign hit_d      = ~frame_tick & (hit_q | collision);

    logic              hit_now, starting, wrap, land;
    logic [9:0]        x_base, x_next, y_phys;
    logic [7:0]        score_base, score_next, dead_cnt_inc;
    logic [10:0]       x_sum;
    logic signed [6:0] vel_cur, vel_phys;
    logic signed [10:0] y_sum;

    assign hit_now      = hit_q | collision;
    assign starting     = jump_req_q & (state_q != ST_JUMP);
    assign vel_cur      = starting ? (7'sd0 - $signed({1'b0, JUMP_V})) : vel_q;
    assign y_sum        = $signed({1'b0, y_q}) + $signed({{4{vel_cur[6]}}, vel_cur});
    assign x_base       = (state_q == ST_IDLE) ? 10'd0 : x_q;
    assign score_base   = (state_q == ST_IDLE) ? 8'd0 : score_q;
    assign x_sum        = {1'b0, x_base} + {1'b0, SCROLL_STEP};
    assign wrap         = x_sum >= {1'b0, SCROLL_WRAP};
    assign x_next       = wrap ? 10'(x_sum - {1'b0, SCROLL_WRAP}) : x_sum[9:0];
    assign score_next   = wrap ? sat_inc8(score_base, 8'd255) : score_base;
    assign dead_cnt_inc = sat_inc8(dead_cnt_q, DEAD_FRAMES);

    // Ceiling clamp only while rising, so a stalled player at CEIL_Y still falls back.
    always_comb begin
        land     = 1'b0;
        y_phys   = y_sum[9:0];
        vel_phys = vel_cur + $signed({1'b0, GRAVITY});
        if (vel_cur[6] && (y_sum <= CEIL_S)) begin
            y_phys   = CEIL_Y;
            vel_phys = '0;
        end else if (y_sum >= GROUND_S) begin
            y_phys   = GROUND_Y;
            vel_phys = '0;
            land     = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        vel_d      = vel_q;
        x_d        = x_q;
        score_d    = score_q;
        dead_cnt_d = dead_cnt_q;
        show_d     = show_q;
        if (frame_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    y_d = GROUND_Y;
                    if (jump_req_q) begin
                        x_d     = x_next;
                        score_d = score_next;
                        y_d     = y_phys;
                        vel_d   = vel_phys;
                        state_d = land ? ST_RUN : ST_JUMP;
                    end
                end
                ST_RUN, ST_JUMP: begin
                    if (hit_now) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = 8'd0;
                        show_d     = 1'b1;
                    end else begin
                        x_d     = x_next;
                        score_d = score_next;
                        if (starting || state_q == ST_JUMP) begin
                            y_d     = y_phys;
                            vel_d   = vel_phys;
                            state_d = land ? ST_RUN : ST_JUMP;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_q == DEAD_FRAMES && jump_req_q) begin
                        state_d = ST_IDLE;
                        y_d     = GROUND_Y;
                        vel_d   = '0;
                        show_d  = 1'b1;
                    end else begin
                        dead_cnt_d = dead_cnt_inc;
                        show_d     = ~dead_cnt_inc[3];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= GROUND_Y;
            vel_q       <= '0;
            x_q         <= 10'd0;
            score_q     <= 8'd0;
            dead_cnt_q  <= 8'd0;
            show_q      <= 1'b1;
            game_over_q <= 1'b0;
            jump_req_q  <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            x_q         <= x_d;
            score_q     <= score_d;
            dead_cnt_q  <= dead_cnt_d;
            show_q      <= show_d;
            game_over_q <= (state_d == ST_DEAD);
            jump_req_q  <= jump_req_d;
            hit_q       <= hit_d;
        end
    end

    assign y_pos       = y_q;
    assign x_offset    = x_q;
    assign score       = score_q;
    assign show_player = show_q;
    assign game_over   = game_over_q;

endmodule
